param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATASIZE, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, entries; power of two, >=4.
REQ-003 Parameter AFULL_LVL, default DEPTH-2, occupancy at or above which o_almost_full asserts.
REQ-004 Parameter AEMPTY_LVL, default 2, occupancy at or below which o_almost_empty asserts.
REQ-005 Parameter FWFT, default 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 wr_en  in  1  write request.
REQ-009 wr_data  in  DATASIZE  write word.
REQ-010 rd_en  in  1  read request (pop in FWFT mode).
REQ-011 rd_data  out  DATASIZE  read word.
REQ-012 rd_valid  out  1  rd_data holds a valid word.
REQ-013 o_fifo_full / o_fifo_empty  out  1 each  status flags.
REQ-014 o_almost_full / o_almost_empty  out  1 each  threshold flags.
REQ-015 o_count  out  ADDRSIZE+1  occupancy, 0..DEPTH; ADDRSIZE = clog2(DEPTH).
REQ-016 o_overflow / o_underflow  out  1 each  sticky error flags.

Function
REQ-017 Write accepted iff wr_en=1 and o_fifo_full=0; word stored at wr_ptr, wr_ptr increments.
REQ-018 Read accepted iff rd_en=1 and o_fifo_empty=0; rd_ptr increments.
REQ-019 Pointers are ADDRSIZE+1-bit binary; MSB is the wrap bit; the low ADDRSIZE bits address memory and wrap DEPTH-1 -> 0.
REQ-020 o_count = wr_ptr - rd_ptr modulo 2^(ADDRSIZE+1); full when count = DEPTH; empty when count = 0.
REQ-021 All flags and o_count are registered, updated on the same edge as the pointers; no extra latency.
REQ-022 Simultaneous accepted write and read: count unchanged, both pointers advance.
REQ-023 At full, wr_en with rd_en: only the read is accepted, and the write is dropped and flagged as an overflow.
REQ-024 At empty, rd_en with wr_en: only the write is accepted, and the read is flagged as an underflow.
REQ-025 Rejected write sets o_overflow; rejected read sets o_underflow; both hold until rst.
REQ-026 o_almost_full = (count >= AFULL_LVL); o_almost_empty = (count <= AEMPTY_LVL).
REQ-027 FWFT=0: rd_data is loaded on the edge that accepts a read, and rd_valid pulses high for exactly that following cycle; otherwise rd_data holds its value.
REQ-028 FWFT=1: rd_data shows the head word and rd_valid = !o_fifo_empty; a write into an empty FIFO is visible on rd_data one cycle after the write edge.

Reset
REQ-029 When rst=1 at an edge, set: pointers 0, o_count 0, o_fifo_empty 1, o_fifo_full 0, o_almost_empty 1, o_almost_full 0, error flags 0, rd_data 0, rd_valid 0.
REQ-030 During a reset cycle, wr_en/rd_en are ignored; a mid-operation rst discards all contents, and memory array contents are not reset.

Structure
REQ-031 Package fifo_pkg holds the pointer-arithmetic helper, the FWFT mode constants, and the ADDRSIZE derivation shared with the asynchronous FIFO.
REQ-032 Storage is one sub-module, sync_fifo_mem: DATASIZE x DEPTH, one synchronous write port, one read port; the control logic stays in param_sync_fifo.

Verification
REQ-033 DEPTH=16, FWFT=0: write 0x01..0x10 -> full=1 after 16th edge, count=16, almost_full from count 14; read 16 -> data 0x01..0x10 in order, rd_valid one cycle after each accepted read, empty=1.
REQ-034 Fill to full, assert wr_en with 0xAA -> word dropped, o_overflow=1 and stays 1; next 16 reads contain no 0xAA.
REQ-035 Empty FIFO, rd_en=1 -> o_underflow=1, rd_valid=0, count stays 0.
REQ-036 Count=8, wr_en and rd_en high for 40 cycles -> count stays 8, pointers wrap, and output order is preserved.
REQ-037 FWFT=1: write 0x5C into empty FIFO -> next cycle rd_data=0x5C, rd_valid=1; pop -> empty=1, rd_valid=0.
REQ-038 Count=9, assert rst for one edge with wr_en=1 -> all outputs at REQ-029 values, count=0, write not stored.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants, address-width derivation and
// the pointer occupancy helper used by both the synchronous and asynchronous FIFOs.
package fifo_pkg;

   localparam int FWFT_STD  = 0;   // registered read, rd_valid pulses per pop
   localparam int FWFT_FALL = 1;   // head word presented continuously

   function automatic int addr_bits(input int depth);
      return $clog2(depth);
   endfunction

   // Occupancy from wrap-bit binary pointers: difference modulo 2^(addr_w+1).
   // Carried at 32 bits so one helper serves every FIFO size; callers narrow it.
   function automatic logic [31:0] ptr_occupancy(input logic [31:0] wr_ptr,
                                                 input logic [31:0] rd_ptr,
                                                 input int          addr_w);
      logic [31:0] mask;
      mask = (32'd1 << (addr_w + 1)) - 32'd1;
      return (wr_ptr - rd_ptr) & mask;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module sync_fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATASIZE = 8,
   parameter int DEPTH    = 16,
   localparam int ADDRSIZE = addr_bits(DEPTH)
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [ADDRSIZE-1:0] wr_addr,
   input  logic [DATASIZE-1:0] wr_data,
   input  logic [ADDRSIZE-1:0] rd_addr,
   output logic [DATASIZE-1:0] rd_data
);

   logic [DATASIZE-1:0] mem [DEPTH];

   // store the incoming word on an accepted write
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO: pointer/flag control plus a selectable
// registered or first-word-fall-through read port.
module param_sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATASIZE   = 8,
   parameter int DEPTH      = 16,
   parameter int AFULL_LVL  = DEPTH - 2,
   parameter int AEMPTY_LVL = 2,
   parameter int FWFT       = FWFT_STD,
   localparam int ADDRSIZE  = addr_bits(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [DATASIZE-1:0] wr_data,
   input  logic                rd_en,
   output logic [DATASIZE-1:0] rd_data,
   output logic                rd_valid,
   output logic                o_fifo_full,
   output logic                o_fifo_empty,
   output logic                o_almost_full,
   output logic                o_almost_empty,
   output logic [ADDRSIZE:0]   o_count,
   output logic                o_overflow,
   output logic                o_underflow
);

   logic [ADDRSIZE:0]   wr_ptr;
   logic [ADDRSIZE:0]   rd_ptr;
   logic [ADDRSIZE:0]   wr_ptr_n;
   logic [ADDRSIZE:0]   rd_ptr_n;
   logic [ADDRSIZE:0]   count_n;
   logic                wr_accept;
   logic                rd_accept;
   logic [DATASIZE-1:0] mem_rd_data;

   // accept decisions and next pointer/occupancy values
   always_comb begin
      wr_accept = wr_en && !o_fifo_full;
      rd_accept = rd_en && !o_fifo_empty;
      wr_ptr_n  = wr_ptr + {{ADDRSIZE{1'b0}}, wr_accept};
      rd_ptr_n  = rd_ptr + {{ADDRSIZE{1'b0}}, rd_accept};
      count_n   = (ADDRSIZE+1)'(ptr_occupancy(32'(wr_ptr_n), 32'(rd_ptr_n), ADDRSIZE));
   end

   // pointers, occupancy and every flag move together on one edge
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         o_count        <= '0;
         o_fifo_full    <= 1'b0;
         o_fifo_empty   <= 1'b1;
         o_almost_full  <= 1'b0;
         o_almost_empty <= 1'b1;
         o_overflow     <= 1'b0;
         o_underflow    <= 1'b0;
      end else begin
         wr_ptr         <= wr_ptr_n;
         rd_ptr         <= rd_ptr_n;
         o_count        <= count_n;
         o_fifo_full    <= (32'(count_n) == DEPTH);
         o_fifo_empty   <= (count_n == '0);
         o_almost_full  <= (32'(count_n) >= AFULL_LVL);
         o_almost_empty <= (32'(count_n) <= AEMPTY_LVL);
         if (wr_en && !wr_accept) o_overflow  <= 1'b1;
         if (rd_en && !rd_accept) o_underflow <= 1'b1;
      end
   end

   // a write arriving with reset must not land in the array
   sync_fifo_mem #(
      .DATASIZE (DATASIZE),
      .DEPTH    (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_accept && !rst),
      .wr_addr (wr_ptr[ADDRSIZE-1:0]),
      .wr_data (wr_data),
      .rd_addr (rd_ptr[ADDRSIZE-1:0]),
      .rd_data (mem_rd_data)
   );

   if (FWFT == FWFT_FALL) begin : g_fwft
      // head word shown directly; forced to zero while empty so the
      // unreset array never leaks onto rd_data
      assign rd_data  = o_fifo_empty ? '0 : mem_rd_data;
      assign rd_valid = !o_fifo_empty;
   end else begin : g_std
      // capture the popped word; rd_valid marks the cycle after each pop
      always_ff @(posedge clk) begin
         if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
         end else begin
            rd_valid <= rd_accept;
            if (rd_accept) rd_data <= mem_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Two FIFO instances (16-deep registered read, 8-deep fall-through) share one
// stimulus stream; a queue model per instance predicts every output each cycle.
module tb_param_sync_fifo;

   localparam int D0 = 16;
   localparam int D1 = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       rd_en = 1'b0;

   logic [7:0] rd_data0, rd_data1;
   logic       rd_valid0, rd_valid1;
   logic       full0, empty0, afull0, aempty0, ovf0, unf0;
   logic       full1, empty1, afull1, aempty1, ovf1, unf1;
   logic [4:0] count0;
   logic [3:0] count1;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   bit         m_ovf0, m_unf0, m_ovf1, m_unf1;
   logic [7:0] m_dat0;
   bit         m_val0;

   always #5 clk = ~clk;

   param_sync_fifo #(.DATASIZE(8), .DEPTH(D0), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data0), .rd_valid(rd_valid0),
      .o_fifo_full(full0), .o_fifo_empty(empty0),
      .o_almost_full(afull0), .o_almost_empty(aempty0),
      .o_count(count0), .o_overflow(ovf0), .o_underflow(unf0)
   );

   param_sync_fifo #(.DATASIZE(8), .DEPTH(D1), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data1), .rd_valid(rd_valid1),
      .o_fifo_full(full1), .o_fifo_empty(empty1),
      .o_almost_full(afull1), .o_almost_empty(aempty1),
      .o_count(count1), .o_overflow(ovf1), .o_underflow(unf1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      int s0, s1;
      logic [7:0] head1;
      s0 = q0.size();
      s1 = q1.size();
      head1 = (s1 > 0) ? q1[0] : 8'h00;
      chk("count0",  32'(count0),   32'(s0));
      chk("full0",   32'(full0),    32'(s0 == D0));
      chk("empty0",  32'(empty0),   32'(s0 == 0));
      chk("afull0",  32'(afull0),   32'(s0 >= D0 - 2));
      chk("aempty0", 32'(aempty0),  32'(s0 <= 2));
      chk("ovf0",    32'(ovf0),     32'(m_ovf0));
      chk("unf0",    32'(unf0),     32'(m_unf0));
      chk("rdata0",  32'(rd_data0), 32'(m_dat0));
      chk("rvalid0", 32'(rd_valid0),32'(m_val0));
      chk("count1",  32'(count1),   32'(s1));
      chk("full1",   32'(full1),    32'(s1 == D1));
      chk("empty1",  32'(empty1),   32'(s1 == 0));
      chk("afull1",  32'(afull1),   32'(s1 >= D1 - 2));
      chk("aempty1", 32'(aempty1),  32'(s1 <= 2));
      chk("ovf1",    32'(ovf1),     32'(m_ovf1));
      chk("unf1",    32'(unf1),     32'(m_unf1));
      chk("rdata1",  32'(rd_data1), 32'(head1));
      chk("rvalid1", 32'(rd_valid1),32'(s1 > 0));
   endtask

   // drive one cycle, advance the models, then compare after the edge
   task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit rs);
      int s0, s1;
      @(negedge clk);
      wr_en = w; wr_data = d; rd_en = r; rst = rs;
      if (rs) begin
         q0.delete(); q1.delete();
         m_ovf0 = 0; m_unf0 = 0; m_ovf1 = 0; m_unf1 = 0;
         m_dat0 = 8'h00; m_val0 = 0;
      end else begin
         s0 = q0.size();
         s1 = q1.size();
         m_val0 = 0;
         if (w && s0 == D0) m_ovf0 = 1;
         if (r && s0 == 0)  m_unf0 = 1;
         if (r && s0 > 0) begin m_dat0 = q0.pop_front(); m_val0 = 1; end
         if (w && s0 < D0) q0.push_back(d);
         if (w && s1 == D1) m_ovf1 = 1;
         if (r && s1 == 0)  m_unf1 = 1;
         if (r && s1 > 0) void'(q1.pop_front());
         if (w && s1 < D1) q1.push_back(d);
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      // reset state
      cycle(0, 8'h00, 0, 1);
      cycle(0, 8'h00, 0, 1);
      chk("rst_empty", 32'(empty0), 32'd1);
      chk("rst_count", 32'(count0), 32'd0);

      // ordered fill and drain of the 16-deep instance
      cycle(0, 8'h00, 0, 0);
      for (int i = 1; i <= 16; i++) begin
         cycle(1, 8'(i), 0, 0);
         if (i == 13) chk("afull_13", 32'(afull0), 32'd0);
         if (i == 14) chk("afull_14", 32'(afull0), 32'd1);
      end
      chk("fill_full", 32'(full0), 32'd1);
      chk("fill_cnt", 32'(count0), 32'd16);
      for (int i = 1; i <= 16; i++) begin
         cycle(0, 8'h00, 1, 0);
         chk("drain_data", 32'(rd_data0), 32'(i));
         chk("drain_valid", 32'(rd_valid0), 32'd1);
      end
      cycle(0, 8'h00, 0, 0);
      chk("drain_vpulse", 32'(rd_valid0), 32'd0);
      chk("drain_empty", 32'(empty0), 32'd1);

      // overflow at full
      for (int i = 0; i < 16; i++) cycle(1, 8'(8'h30 + i), 0, 0);
      cycle(1, 8'hAA, 0, 0);
      chk("ovf_set", 32'(ovf0), 32'd1);
      for (int i = 0; i < 16; i++) begin
         cycle(0, 8'h00, 1, 0);
         chk("no_aa", 32'(rd_data0 == 8'hAA), 32'd0);
      end
      chk("ovf_hold", 32'(ovf0), 32'd1);

      // underflow at empty
      cycle(0, 8'h00, 1, 0);
      chk("unf_set", 32'(unf0), 32'd1);
      chk("unf_valid", 32'(rd_valid0), 32'd0);
      chk("unf_cnt", 32'(count0), 32'd0);

      // steady occupancy with concurrent push/pop across pointer wrap
      cycle(0, 8'h00, 0, 1);
      for (int i = 0; i < 8; i++) cycle(1, 8'($urandom), 0, 0);
      for (int i = 0; i < 40; i++) begin
         cycle(1, 8'($urandom), 1, 0);
         chk("steady_cnt", 32'(count0), 32'd8);
      end

      // fall-through visibility
      cycle(0, 8'h00, 0, 1);
      cycle(1, 8'h5C, 0, 0);
      chk("fwft_data", 32'(rd_data1), 32'h5C);
      chk("fwft_valid", 32'(rd_valid1), 32'd1);
      cycle(0, 8'h00, 1, 0);
      chk("fwft_empty", 32'(empty1), 32'd1);
      chk("fwft_vlow", 32'(rd_valid1), 32'd0);

      // reset mid-operation with a write pending
      cycle(0, 8'h00, 0, 1);
      for (int i = 0; i < 9; i++) cycle(1, 8'(8'h60 + i), 0, 0);
      cycle(1, 8'h77, 0, 1);
      chk("mrst_cnt", 32'(count0), 32'd0);
      chk("mrst_aempty", 32'(aempty0), 32'd1);
      chk("mrst_rdata", 32'(rd_data0), 32'd0);
      cycle(0, 8'h00, 0, 0);
      chk("mrst_nostore", 32'(count0), 32'd0);

      // randomized traffic with shifting write/read bias and rare resets
      for (int blk = 0; blk < 12; blk++) begin
         int pw, pr;
         pw = $urandom_range(10, 90);
         pr = $urandom_range(10, 90);
         for (int i = 0; i < 150; i++) begin
            cycle($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr,
                  $urandom_range(199) == 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
